vx_cache_bank_req_scheduler: RTL and testbench

//  Multi-cycle core-request-to-bank dispatcher between the core request port and the banks.

---
 rtl/vx_cache_bank_req_scheduler_if.sv | 27 ++
 rtl/vx_cache_bank_req_scheduler.sv | 150 +++++++++++++++
 tb/tb_vx_cache_bank_req_scheduler.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vx_cache_bank_req_scheduler_if.sv
// Core request batch and per-bank offer signals between the core, the scheduler and the banks.
// master = core/bank side, slave = scheduler.
interface vx_cache_bank_req_scheduler_if #(
   parameter int NUM_BANKS       = 4,
   parameter int NUM_REQUESTS    = 4,
   parameter int WORD_ADDR_WIDTH = 30,
   parameter int REQ_IDX_W       = (NUM_REQUESTS > 1) ? $clog2(NUM_REQUESTS) : 1
);
   logic [NUM_REQUESTS-1:0]                 core_req_valid;
   logic [NUM_REQUESTS*WORD_ADDR_WIDTH-1:0] core_req_addr;
   logic                                    split_en;
   logic                                    core_req_ready;
   logic [NUM_BANKS-1:0]                    per_bank_ready;
   logic [NUM_BANKS-1:0]                    per_bank_valid;
   logic [NUM_BANKS*REQ_IDX_W-1:0]          per_bank_req_idx;
   logic [NUM_BANKS*WORD_ADDR_WIDTH-1:0]    per_bank_addr;

   modport master (
      output core_req_valid, core_req_addr, split_en, per_bank_ready,
      input  core_req_ready, per_bank_valid, per_bank_req_idx, per_bank_addr
   );

   modport slave (
      input  core_req_valid, core_req_addr, split_en, per_bank_ready,
      output core_req_ready, per_bank_valid, per_bank_req_idx, per_bank_addr
   );
endinterface

// File: rtl/vx_cache_bank_req_scheduler.sv
// Dispatches a batch of core word requests to banks, one per bank per cycle; bank conflicts are
// serialised over several cycles using a round-robin pointer per bank.
// state   | meaning
// ST_IDLE | ready for a batch; candidates, addresses and mode come straight from the inputs
// ST_BUSY | draining pend_r using the addresses and mode latched at accept
module vx_cache_bank_req_scheduler #(
   parameter int BANK_LINE_SIZE  = 16,
   parameter int WORD_SIZE       = 4,
   parameter int NUM_BANKS       = 4,
   parameter int NUM_REQUESTS    = 4,
   parameter int WORD_ADDR_WIDTH = 30
) (
   input logic                          clk,
   input logic                          reset,
   vx_cache_bank_req_scheduler_if.slave bus
);
   localparam int BANK_SEL_LSB = $clog2(BANK_LINE_SIZE / WORD_SIZE);
   localparam int BANK_SEL_W   = $clog2(NUM_BANKS);
   localparam int BANK_W       = (BANK_SEL_W > 0) ? BANK_SEL_W : 1;
   localparam int REQ_IDX_W    = (NUM_REQUESTS > 1) ? $clog2(NUM_REQUESTS) : 1;
   localparam int NR           = NUM_REQUESTS;
   localparam int NB           = NUM_BANKS;
   localparam int AW           = WORD_ADDR_WIDTH;

   typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

   state_t               state_r, state_n;
   logic [NR-1:0]        pend_r, pend_n;
   logic [AW-1:0]        addr_r [NR];
   logic                 split_r;
   logic [REQ_IDX_W-1:0] rr_ptr [NB];

   logic [NR-1:0]        cand, fired_lanes, remaining;
   logic [AW-1:0]        lane_addr [NR];
   logic [BANK_W-1:0]    addr_bank [NR];
   logic [BANK_W-1:0]    lane_bank [NR];
   logic                 lane_split, accept;
   logic [NB-1:0]        sel_valid, fire;
   logic [REQ_IDX_W-1:0] sel_idx [NB];
   logic [REQ_IDX_W-1:0] rr_next [NB];

   always_comb begin
      lane_split = (state_r == ST_BUSY) ? split_r : bus.split_en;
      cand       = (state_r == ST_BUSY) ? pend_r  : bus.core_req_valid;
      for (int i = 0; i < NR; i++) begin
         lane_addr[i] = (state_r == ST_BUSY) ? addr_r[i] : bus.core_req_addr[i*AW +: AW];
      end
   end

   for (genvar i = 0; i < NR; i++) begin : g_lane
      if (BANK_SEL_W > 0) begin : g_addr_sel
         assign addr_bank[i] = lane_addr[i][BANK_SEL_LSB +: BANK_W];
      end else begin : g_single_bank
         assign addr_bank[i] = '0;
      end
      assign lane_bank[i] = lane_split ? BANK_W'(i % NB) : addr_bank[i];
   end

   // Search starts at the bank's pointer, so a stalled bank keeps offering the same lane.
   always_comb begin
      logic [REQ_IDX_W-1:0] lane;
      lane = '0;
      for (int b = 0; b < NB; b++) begin
         sel_valid[b] = 1'b0;
         sel_idx[b]   = '0;
         for (int k = 0; k < NR; k++) begin
            lane = REQ_IDX_W'((int'(rr_ptr[b]) + k) % NR);
            if (!sel_valid[b] && cand[lane] && (lane_bank[lane] == BANK_W'(b))) begin
               sel_valid[b] = 1'b1;
               sel_idx[b]   = lane;
            end
         end
      end
   end

   always_comb begin
      fired_lanes = '0;
      for (int b = 0; b < NB; b++) begin
         fire[b]    = sel_valid[b] & bus.per_bank_ready[b];
         rr_next[b] = REQ_IDX_W'((int'(sel_idx[b]) + 1) % NR);
         if (fire[b]) begin
            fired_lanes[sel_idx[b]] = 1'b1;
         end
      end
      remaining = cand & ~fired_lanes;
      accept    = (state_r == ST_IDLE) && (|bus.core_req_valid);
   end

   always_comb begin
      state_n = state_r;
      pend_n  = pend_r;
      case (state_r)
         ST_IDLE: begin
            if (accept && (|remaining)) begin
               state_n = ST_BUSY;
               pend_n  = remaining;
            end
         end
         ST_BUSY: begin
            pend_n = remaining;
            if (remaining == '0) begin
               state_n = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
         pend_r  <= '0;
         split_r <= 1'b0;
         for (int i = 0; i < NR; i++) begin
            addr_r[i] <= '0;
         end
         for (int b = 0; b < NB; b++) begin
            rr_ptr[b] <= '0;
         end
      end else begin
         state_r <= state_n;
         pend_r  <= pend_n;
         if (accept && (|remaining)) begin
            split_r <= bus.split_en;
            for (int i = 0; i < NR; i++) begin
               addr_r[i] <= bus.core_req_addr[i*AW +: AW];
            end
         end
         for (int b = 0; b < NB; b++) begin
            if (fire[b]) begin
               rr_ptr[b] <= rr_next[b];
            end
         end
      end
   end

   // Outputs are forced low while reset is held, including core_req_ready.
   always_comb begin
      bus.core_req_ready   = reset && (state_r == ST_IDLE);
      bus.per_bank_valid   = '0;
      bus.per_bank_req_idx = '0;
      bus.per_bank_addr    = '0;
      for (int b = 0; b < NB; b++) begin
         if (reset && sel_valid[b]) begin
            bus.per_bank_valid[b]                      = 1'b1;
            bus.per_bank_req_idx[b*REQ_IDX_W +: REQ_IDX_W] = sel_idx[b];
            bus.per_bank_addr[b*AW +: AW]              = lane_addr[sel_idx[b]];
         end
      end
   end
endmodule

// File: tb/tb_vx_cache_bank_req_scheduler.sv
// Scoreboard bench: a lane/bank reference model pushes the expected per-cycle offer, a negedge
// monitor pops and compares. dut0 has 4 banks, dut1 has 2 banks; both have 4 lanes.
module tb_vx_cache_bank_req_scheduler;
   localparam int AW = 30;

   typedef struct packed {
      logic         ready;
      logic [3:0]   valid;
      logic [7:0]   idx;
      logic [119:0] addr;
   } exp_t;

   logic clk = 1'b0;
   logic rst0, rst1;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_cyc   = 0;
   exp_t q0[$], q1[$];

   int            m_busy  [2];
   bit            m_pend  [2][4];
   logic [AW-1:0] m_addr  [2][4];
   bit            m_split [2];
   int            m_rr    [2][4];

   always #5 clk = ~clk;

   vx_cache_bank_req_scheduler_if #(.NUM_BANKS(4), .NUM_REQUESTS(4), .WORD_ADDR_WIDTH(AW)) bus0 ();
   vx_cache_bank_req_scheduler_if #(.NUM_BANKS(2), .NUM_REQUESTS(4), .WORD_ADDR_WIDTH(AW)) bus1 ();

   vx_cache_bank_req_scheduler #(
      .BANK_LINE_SIZE(16), .WORD_SIZE(4), .NUM_BANKS(4), .NUM_REQUESTS(4), .WORD_ADDR_WIDTH(AW)
   ) dut0 (.clk(clk), .reset(rst0), .bus(bus0));

   vx_cache_bank_req_scheduler #(
      .BANK_LINE_SIZE(16), .WORD_SIZE(4), .NUM_BANKS(2), .NUM_REQUESTS(4), .WORD_ADDR_WIDTH(AW)
   ) dut1 (.clk(clk), .reset(rst1), .bus(bus1));

   task automatic model_clear(input int d);
      m_busy[d]  = 0;
      m_split[d] = 0;
      for (int i = 0; i < 4; i++) begin
         m_pend[d][i] = 0;
         m_addr[d][i] = '0;
         m_rr[d][i]   = 0;
      end
   endtask

   // Evaluates one cycle of the reference from the stimulus just driven, then advances it.
   task automatic model_eval(input int d);
      int            nb, lane, bank, pick;
      logic          rv, spin;
      logic [3:0]    vin, rdy;
      logic [119:0]  ain;
      bit            sp, found, any_rem;
      bit            cand [4];
      bit            fired [4];
      bit            rem [4];
      logic [AW-1:0] la [4];
      exp_t          e;
      if (d == 0) begin
         nb = 4; rv = rst0; vin = bus0.core_req_valid; ain = bus0.core_req_addr;
         spin = bus0.split_en; rdy = bus0.per_bank_ready;
      end else begin
         nb = 2; rv = rst1; vin = bus1.core_req_valid; ain = bus1.core_req_addr;
         spin = bus1.split_en; rdy = {2'b00, bus1.per_bank_ready};
      end
      e = '0;
      if (!rv) begin
         model_clear(d);
      end else begin
         for (int i = 0; i < 4; i++) begin
            cand[i]  = (m_busy[d] != 0) ? m_pend[d][i] : bit'(vin[i]);
            la[i]    = (m_busy[d] != 0) ? m_addr[d][i] : ain[i*AW +: AW];
            fired[i] = 0;
         end
         sp      = (m_busy[d] != 0) ? m_split[d] : bit'(spin);
         e.ready = (m_busy[d] == 0);
         for (int b = 0; b < nb; b++) begin
            found = 0;
            pick  = 0;
            for (int k = 0; k < 4; k++) begin
               lane = (m_rr[d][b] + k) % 4;
               bank = sp ? (lane % nb) : (int'(la[lane] >> 2) % nb);
               if (!found && cand[lane] && bank == b) begin
                  found = 1;
                  pick  = lane;
               end
            end
            if (found) begin
               e.valid[b]          = 1'b1;
               e.idx[b*2 +: 2]     = 2'(pick);
               e.addr[b*AW +: AW]  = la[pick];
               if (rdy[b]) begin
                  fired[pick] = 1;
                  m_rr[d][b]  = (pick + 1) % 4;
               end
            end
         end
         any_rem = 0;
         for (int i = 0; i < 4; i++) begin
            rem[i] = cand[i] && !fired[i];
            if (rem[i]) any_rem = 1;
         end
         if (m_busy[d] == 0) begin
            if (vin != 4'h0 && any_rem) begin
               m_busy[d]  = 1;
               m_split[d] = spin;
               for (int i = 0; i < 4; i++) begin
                  m_addr[d][i] = la[i];
                  m_pend[d][i] = rem[i];
               end
            end
         end else begin
            for (int i = 0; i < 4; i++) m_pend[d][i] = rem[i];
            m_busy[d] = any_rem ? 1 : 0;
         end
      end
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic check(input int d, input exp_t e, input logic ar, input logic [3:0] av,
                        input logic [7:0] ai, input logic [119:0] aa);
      n_tests++;
      if (ar !== e.ready) begin
         n_fail++;
         $display("FAIL dut%0d cycle %0d core_req_ready got %b want %b", d, n_cyc, ar, e.ready);
      end
      n_tests++;
      if (av !== e.valid) begin
         n_fail++;
         $display("FAIL dut%0d cycle %0d per_bank_valid got %b want %b", d, n_cyc, av, e.valid);
      end
      n_tests++;
      if (ai !== e.idx) begin
         n_fail++;
         $display("FAIL dut%0d cycle %0d per_bank_req_idx got %h want %h", d, n_cyc, ai, e.idx);
      end
      n_tests++;
      if (aa !== e.addr) begin
         n_fail++;
         $display("FAIL dut%0d cycle %0d per_bank_addr got %h want %h", d, n_cyc, aa, e.addr);
      end
   endtask

   task automatic check_reset_zero();
      n_tests++;
      if (bus0.core_req_ready !== 1'b0 || bus0.per_bank_valid !== 4'h0 ||
          bus0.per_bank_req_idx !== 8'h0 || bus0.per_bank_addr !== 120'h0) begin
         n_fail++;
         $display("FAIL dut0 reset_outputs got ready=%b valid=%b idx=%h want all zero",
                  bus0.core_req_ready, bus0.per_bank_valid, bus0.per_bank_req_idx);
      end
   endtask

   always @(negedge clk) begin
      n_cyc++;
      if (q0.size() != 0)
         check(0, q0.pop_front(), bus0.core_req_ready, bus0.per_bank_valid,
               bus0.per_bank_req_idx, bus0.per_bank_addr);
      if (q1.size() != 0)
         check(1, q1.pop_front(), bus1.core_req_ready, {2'b00, bus1.per_bank_valid},
               {4'h0, bus1.per_bank_req_idx}, {60'h0, bus1.per_bank_addr});
   end

   task automatic drive(input int d, input logic r, input logic [3:0] v, input logic [119:0] a,
                        input logic sp, input logic [3:0] rd);
      if (d == 0) begin
         rst0 = r; bus0.core_req_valid = v; bus0.core_req_addr = a;
         bus0.split_en = sp; bus0.per_bank_ready = rd;
      end else begin
         rst1 = r; bus1.core_req_valid = v; bus1.core_req_addr = a;
         bus1.split_en = sp; bus1.per_bank_ready = rd[1:0];
      end
   endtask

   function automatic logic [119:0] pack4(input logic [AW-1:0] a0, a1, a2, a3);
      return {a3, a2, a1, a0};
   endfunction

   function automatic logic [119:0] rand_addrs();
      logic [119:0] r;
      for (int i = 0; i < 4; i++) r[i*AW +: AW] = AW'($urandom);
      return r;
   endfunction

   function automatic logic [3:0] rand_ready();
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = ($urandom_range(0, 3) != 0);
      return r;
   endfunction

   function automatic logic [3:0] rand_valid();
      return ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      model_eval(0);
      model_eval(1);
   endtask

   task automatic tick0(input logic [3:0] v, input logic [119:0] a, input logic sp, input logic [3:0] rd);
      cyc();
      drive(0, 1'b1, v, a, sp, rd);
      drive(1, 1'b1, 4'h0, '0, 1'b0, 4'hF);
      step();
   endtask

   task automatic tick1(input logic [3:0] v, input logic [119:0] a, input logic sp, input logic [3:0] rd);
      cyc();
      drive(0, 1'b1, 4'h0, '0, 1'b0, 4'hF);
      drive(1, 1'b1, v, a, sp, rd);
      step();
   endtask

   initial begin
      logic [119:0] t2_addr;
      t2_addr = pack4(30'd8, 30'd24, 30'd40, 30'd56);
      model_clear(0);
      model_clear(1);
      drive(0, 1'b0, 4'h0, '0, 1'b0, 4'h0);
      drive(1, 1'b0, 4'h0, '0, 1'b0, 4'h0);
      repeat (2) begin
         cyc();
         drive(0, 1'b0, 4'h0, '0, 1'b0, 4'hF);
         drive(1, 1'b0, 4'h0, '0, 1'b0, 4'hF);
         step();
      end

      // all four lanes on bank 2, fresh pointers
      tick0(4'hF, t2_addr, 1'b0, 4'hF);
      repeat (3) tick0(4'hF, rand_addrs(), 1'b0, 4'hF);
      tick0(4'h0, '0, 1'b0, 4'hF);
      // conflict-free batch
      tick0(4'hF, pack4(30'd0, 30'd4, 30'd8, 30'd12), 1'b0, 4'hF);
      // bank 1 stalled for three cycles
      tick0(4'b0011, pack4(30'd4, 30'd20, 30'd0, 30'd0), 1'b0, 4'b1101);
      repeat (2) tick0(4'h0, '0, 1'b0, 4'b1101);
      repeat (3) tick0(4'h0, '0, 1'b0, 4'hF);
      // pointer persistence across batches on bank 0
      tick0(4'b0010, pack4(30'd0, 30'd32, 30'd0, 30'd0), 1'b0, 4'hF);
      tick0(4'b1001, pack4(30'd16, 30'd0, 30'd0, 30'd48), 1'b0, 4'hF);
      repeat (2) tick0(4'h0, '0, 1'b0, 4'hF);

      // reset held across an edge in the middle of a busy batch
      tick0(4'hF, t2_addr, 1'b0, 4'hF);
      cyc();
      drive(0, 1'b0, 4'h0, '0, 1'b0, 4'hF);
      #1 check_reset_zero();
      drive(1, 1'b1, 4'h0, '0, 1'b0, 4'hF);
      step();
      repeat (2) tick0(4'h0, '0, 1'b0, 4'hF);

      // short reset pulse between edges must still clear the batch
      tick0(4'hF, t2_addr, 1'b0, 4'hF);
      cyc();
      rst0 = 1'b0;
      #1 check_reset_zero();
      rst0 = 1'b1;
      model_clear(0);
      drive(0, 1'b1, 4'h0, '0, 1'b0, 4'hF);
      drive(1, 1'b1, 4'h0, '0, 1'b0, 4'hF);
      step();
      repeat (2) tick0(4'h0, '0, 1'b0, 4'hF);

      // lane-split mode with fewer banks than lanes
      tick1(4'hF, rand_addrs(), 1'b1, 4'hF);
      repeat (2) tick1(4'h0, '0, 1'b0, 4'hF);

      repeat (1500) begin
         cyc();
         drive(0, ($urandom_range(0, 99) != 0), rand_valid(), rand_addrs(),
               1'($urandom_range(0, 1)), rand_ready());
         drive(1, ($urandom_range(0, 99) != 0), rand_valid(), rand_addrs(),
               1'($urandom_range(0, 1)), rand_ready());
         step();
      end

      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
